// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline latch and a one-cycle BOOT hold after reset.
// Optional perf counters (fetch_count, flush_count) are built when FETCH_PERF_CNT_EN is defined.
//
// state | meaning
// BOOT  | first cycle after reset; PC held, IF/ID invalid, stall/branch ignored
// RUN   | normal fetch: redirect > stall > advance

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] imem_data,
    output logic [7:0]  imem_addr,
    output logic [31:0] pc_current,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus_4,
    output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic [31:0] pc_plus_4_d;
    logic        valid_d;
    logic [31:0] pc_plus_4;

`ifdef FETCH_PERF_CNT_EN
    logic fetch_inc;
    logic flush_inc;
`endif

    assign pc_plus_4 = pc_current + 32'd4;
    assign imem_addr = pc_current[7:0];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_current;
        instr_d     = if_id_instr;
        pc_plus_4_d = if_id_pc_plus_4;
        valid_d     = if_id_valid;
`ifdef FETCH_PERF_CNT_EN
        fetch_inc   = 1'b0;
        flush_inc   = 1'b0;
`endif
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (branch_taken) begin
                    // Target is word-aligned; the low two address bits are dropped.
                    pc_d        = branch_target & ~32'h3;
                    instr_d     = 32'h0;
                    pc_plus_4_d = 32'h0;
                    valid_d     = 1'b0;
`ifdef FETCH_PERF_CNT_EN
                    flush_inc   = 1'b1;
`endif
                end else if (!stall) begin
                    pc_d        = pc_plus_4;
                    instr_d     = imem_data;
                    pc_plus_4_d = pc_plus_4;
                    valid_d     = 1'b1;
`ifdef FETCH_PERF_CNT_EN
                    fetch_inc   = 1'b1;
`endif
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= BOOT;
            pc_current      <= RESET_PC;
            if_id_instr     <= 32'h0;
            if_id_pc_plus_4 <= 32'h0;
            if_id_valid     <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_current      <= pc_d;
            if_id_instr     <= instr_d;
            if_id_pc_plus_4 <= pc_plus_4_d;
            if_id_valid     <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= 32'h0;
            flush_count <= 32'h0;
        end else begin
            if (fetch_inc) fetch_count <= fetch_count + 32'd1;
            if (flush_inc) flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns its own byte address (word k holds k*4).
// Counter checks compile only when FETCH_PERF_CNT_EN is defined.

module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_data;
    logic [7:0]  imem_addr;
    logic [31:0] pc_current;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus_4;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_data       (imem_data),
        .imem_addr       (imem_addr),
        .pc_current      (pc_current),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus_4 (if_id_pc_plus_4),
        .if_id_valid     (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count),
        .flush_count     (flush_count)
`endif
    );

    assign imem_data = {24'h0, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] pp4, input logic valid);
        check({tag, "_pc"}, pc_current, pc);
        check({tag, "_instr"}, if_id_instr, instr);
        check({tag, "_pp4"}, if_id_pc_plus_4, pp4);
        check({tag, "_valid"}, {31'h0, if_id_valid}, {31'h0, valid});
    endtask

    initial begin
        reset         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        repeat (3) tick();
        check_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check("reset_addr", {24'h0, imem_addr}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("reset_fcnt", fetch_count, 32'h0);
        check("reset_xcnt", flush_count, 32'h0);
`endif

        // cold start: BOOT edge, then three fetches
        reset = 1'b1;
        tick(); check_if("boot", 32'h0, 32'h0, 32'h0, 1'b0);
        tick(); check_if("f0", 32'h4, 32'h0, 32'h4, 1'b1);
        tick(); check_if("f1", 32'h8, 32'h4, 32'h8, 1'b1);
        tick(); check_if("f2", 32'hC, 32'h8, 32'hC, 1'b1);
        tick(); check_if("f3", 32'h10, 32'hC, 32'h10, 1'b1);

        // stall two cycles at 0x10
        stall = 1'b1;
        tick(); check_if("stall0", 32'h10, 32'hC, 32'h10, 1'b1);
        tick(); check_if("stall1", 32'h10, 32'hC, 32'h10, 1'b1);
        stall = 1'b0;
        tick(); check_if("resume", 32'h14, 32'h10, 32'h14, 1'b1);

        // redirect to unaligned 0x27 -> 0x24
        branch_taken  = 1'b1;
        branch_target = 32'h27;
        tick(); check_if("br", 32'h24, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check("cnt_fetch5", fetch_count, 32'd5);
        check("cnt_flush1", flush_count, 32'd1);
`endif
        branch_taken = 1'b0;
        tick(); check_if("br_tgt", 32'h28, 32'h24, 32'h28, 1'b1);

        // branch and stall together: branch wins
        branch_taken  = 1'b1;
        stall         = 1'b1;
        branch_target = 32'h40;
        tick(); check_if("br_stall", 32'h40, 32'h0, 32'h0, 1'b0);
        branch_taken = 1'b0;
        stall        = 1'b0;
        tick(); check_if("br_stall_tgt", 32'h44, 32'h40, 32'h44, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        check("cnt_fetch7", fetch_count, 32'd7);
        check("cnt_flush2", flush_count, 32'd2);
`endif

        // reach 0x30, then pulse reset between edges
        branch_taken  = 1'b1;
        branch_target = 32'h2C;
        tick(); check("to_2c_pc", pc_current, 32'h2C);
        branch_taken = 1'b0;
        tick(); check_if("at_30", 32'h30, 32'h2C, 32'h30, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_if("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check("async_fcnt", fetch_count, 32'h0);
        check("async_xcnt", flush_count, 32'h0);
`endif
        #1;
        reset = 1'b1;

        // BOOT ignores branch and stall
        branch_taken  = 1'b1;
        stall         = 1'b1;
        branch_target = 32'h80;
        tick(); check_if("boot2", 32'h0, 32'h0, 32'h0, 1'b0);
        branch_taken = 1'b0;
        stall        = 1'b0;
        tick(); check_if("g0", 32'h4, 32'h0, 32'h4, 1'b1);
        tick(); check_if("g1", 32'h8, 32'h4, 32'h8, 1'b1);
        tick(); check_if("g2", 32'hC, 32'h8, 32'hC, 1'b1);

        // PC wrap and imem_addr aliasing
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        tick(); check_if("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        check("alias_addr", {24'h0, imem_addr}, 32'hFC);
        branch_taken = 1'b0;
        tick(); check_if("wrap", 32'h0, 32'hFC, 32'h0, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        check("end_fcnt", fetch_count, 32'd4);
        check("end_xcnt", flush_count, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
